// File: rtl/alu_exec_stage.sv
// ALU execute stage: one-hot decoded 16-function ALU feeding a 2-entry result queue.
// Optional build macro ALU_ONEHOT_CHECK_EN flags op vectors that are not exactly one-hot.
module alu_exec_stage #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [15:0]           op_onehot,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_ovf,
  output logic                  out_err,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int QDEPTH = 2;
  localparam int MSB    = DATA_WIDTH - 1;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_ID,  OP_NOT,  OP_AND, OP_OR,  OP_NAND, OP_NOR,
    OP_XOR, OP_XNOR, OP_LLS, OP_LRS, OP_ALS, OP_ARS, OP_TCP,  OP_ZERO
  } op_e;

  op_e             op_sel;
  logic            op_any;
  logic [MSB:0]    sum;
  logic [MSB:0]    diff;
  logic [MSB:0]    res;
  logic            ovf;
  logic            err;

  assign sum  = in_a + in_b;
  assign diff = in_a - in_b;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    op_sel = OP_ZERO;
    op_any = 1'b0;
    res    = '0;
    ovf    = 1'b0;
    err    = 1'b0;
    // Lowest set bit wins; an all-zero vector falls through to ZERO.
    for (int i = 0; i < 16; i++) begin
      if (op_onehot[i] && !op_any) begin
        op_sel = op_e'(4'(i));
        op_any = 1'b1;
      end
    end
    case (op_sel)
      OP_ADD: begin
        res = sum;
        ovf = (in_a[MSB] == in_b[MSB]) && (sum[MSB] != in_a[MSB]);
      end
      OP_SUB: begin
        res = diff;
        ovf = (in_a[MSB] != in_b[MSB]) && (diff[MSB] != in_a[MSB]);
      end
      OP_ID:   res = in_a;
      OP_NOT:  res = ~in_a;
      OP_AND:  res = in_a & in_b;
      OP_OR:   res = in_a | in_b;
      OP_NAND: res = ~(in_a & in_b);
      OP_NOR:  res = ~(in_a | in_b);
      OP_XOR:  res = in_a ^ in_b;
      OP_XNOR: res = ~(in_a ^ in_b);
      OP_LLS:  res = {in_a[MSB-1:0], 1'b0};
      OP_LRS:  res = {1'b0, in_a[MSB:1]};
      OP_ALS:  res = {in_a[MSB-1:0], 1'b0};
      OP_ARS:  res = {in_a[MSB], in_a[MSB:1]};
      OP_TCP:  res = -in_a;
      default: res = '0;
    endcase
`ifdef ALU_ONEHOT_CHECK_EN
    if ((op_onehot == 16'h0000) || ((op_onehot & (op_onehot - 16'd1)) != 16'h0000)) begin
      res = '0;
      ovf = 1'b0;
      err = 1'b1;
    end
`endif
  end

  logic [MSB:0] mem_result [QDEPTH];
  logic         mem_ovf    [QDEPTH];
  logic         mem_err    [QDEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         ready_en;
  logic         push;
  logic         pop;

  // ready_en holds in_ready low through reset and releases it on the first edge after.
  assign in_ready  = ready_en && ((count < 2'(QDEPTH)) || out_ready);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_result = out_valid ? mem_result[rd_ptr] : '0;
  assign out_ovf    = out_valid ? mem_ovf[rd_ptr]    : 1'b0;
  assign out_err    = out_valid ? mem_err[rd_ptr]    : 1'b0;

  // NOTE: storage has no reset; outputs are masked by out_valid, so stale contents never leak.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_result[wr_ptr] <= res;
      mem_ovf[wr_ptr]    <= ovf;
      mem_err[wr_ptr]    <= err;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 Parameter: DATA_WIDTH, default 16, operand/result width in bits.
REQ-002 Parameter: QDEPTH, fixed 2, result-queue depth in entries; not overridable.
REQ-003 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: op_onehot  input  16  one-hot operation vector from the 4-to-16 op decoder; bit k = func code k.
REQ-006 Port: in_a, in_b  input  DATA_WIDTH each  operands.
REQ-007 Port: in_valid / in_ready  input / output  1 each  upstream handshake; transfer when both high at a rising edge.
REQ-008 Port: out_result  output  DATA_WIDTH  result at queue head.
REQ-009 Port: out_ovf  output  1  signed overflow of ADD/SUB at queue head; 0 for other ops.
REQ-010 Port: out_err  output  1  illegal op vector flag at queue head.
REQ-011 Port: out_valid / out_ready  output / input  1 each  downstream handshake; pop when both high at a rising edge.

Function
REQ-012 Op map, bit 0..15: ADD, SUB, ID(A), NOT(A), AND, OR, NAND, NOR, XOR, XNOR, LLS(A<<1), LRS(A>>1 logical), ALS(A<<<1), ARS(A>>>1 arithmetic), TCP(-A), ZERO.
REQ-013 Arithmetic modulo 2^DATA_WIDTH; carry discarded; out_ovf = signed overflow, ADD/SUB only.
REQ-014 Result computed combinationally on accept, written into a 2-entry FIFO; accept-to-out_valid latency exactly 1 cycle.
REQ-015 in_ready = 1 when occupancy < 2, or occupancy = 2 and out_ready = 1 (pop same cycle); no combinational in_valid->in_ready path.
REQ-016 out_valid = (occupancy != 0); out_result/out_ovf/out_err stable while out_valid=1 and out_ready=0.
REQ-017 Simultaneous push and pop: occupancy unchanged, order preserved, no entry lost or duplicated.
REQ-018 Empty queue with simultaneous push: entry not visible same cycle (no bypass); out_valid rises next cycle.
REQ-019 Pointers 1-bit, wrap 1->0; occupancy 0..2, never exceeds 2.
REQ-020 Sustained throughput 1 op/cycle when out_ready held high.
REQ-021 When out_valid=0, out_result/out_ovf/out_err drive 0.

Reset
REQ-022 reset_n low asynchronously clears occupancy and pointers; out_valid=0, out_result=0, out_ovf=0, out_err=0 immediately.
REQ-023 in_ready = 0 while reset_n low; 1 from first clock edge after deassertion.
REQ-024 Reset mid-operation discards all queued entries; no partial result emitted after release.

Configuration
REQ-025 Macro ALU_ONEHOT_CHECK_EN defined: op_onehot with zero or multiple bits set -> entry stored with out_err=1, out_result=0, out_ovf=0.
REQ-026 Macro undefined: out_err tied 0; illegal vector resolved by lowest set bit; all-zero vector -> result 0.

Verification
REQ-027 Reset then ADD A=16'h7FFF B=16'h0001, out_ready=1 -> next cycle out_valid=1, result 16'h8000, ovf=1.
REQ-028 SUB A=16'h0003 B=16'h0005 -> result 16'hFFFE, ovf=0; ARS A=16'h8004 -> 16'hC002; LRS A=16'h8004 -> 16'h4002.
REQ-029 out_ready=0, push 3 ops -> third stalls (in_ready=0 after 2 accepted); out_ready=1 -> results in issue order, none lost.
REQ-030 Back-to-back 16 ops, one per func code, out_ready=1 -> 16 results on consecutive cycles, all match REQ-012.
REQ-031 With ALU_ONEHOT_CHECK_EN: op_onehot=16'h0003 -> out_err=1, result 0; without: same vector -> ADD result, out_err=0.
REQ-032 2 entries queued, assert reset_n=0 mid-cycle -> out_valid=0 immediately; after release, no stale result appears.
